// File: rtl/fc_cfg_pkg.sv
// Shared configuration constants for the counter datapath register bank.
// Register indices, default geometry and the standard mask/reset vectors.
package fc_cfg_pkg;

  localparam int unsigned REG_THR  = 0;
  localparam int unsigned REG_GAIN = 1;
  localparam int unsigned REG_MODE = 2;

  localparam int unsigned CFG_NREG = 3;
  localparam int unsigned CFG_DW   = 8;
  localparam int unsigned CFG_AW   = 4;

  // MODE keeps 4 bits, GAIN 6 bits, THR all 8 bits
  localparam logic [CFG_NREG*CFG_DW-1:0] CFG_WMASK   = 24'h0F_3F_FF;
  localparam logic [CFG_NREG*CFG_DW-1:0] CFG_RST_VAL = 24'h00_3F_A5;

endpackage

// File: rtl/shadow_reg.sv
// One configuration register: shadow copy loaded by host writes, active copy
// loaded from the shadow (or the same-cycle write data) on commit.
module shadow_reg #(
  parameter int unsigned     DW      = 8,
  parameter logic [DW-1:0]   MASK    = '1,
  parameter logic [DW-1:0]   RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          commit,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] shadow,
  output logic [DW-1:0] active
);

  localparam logic [DW-1:0] RST_MASKED = RST_VAL & MASK;

  // A write merged with a commit goes straight through to the active copy
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= RST_MASKED;
      active <= RST_MASKED;
    end else begin
      if (we) begin
        shadow <= wdata & MASK;
      end
      if (commit) begin
        active <= we ? (wdata & MASK) : shadow;
      end
    end
  end

endmodule

// File: rtl/reg_bank_cfg.sv
// Configuration register bank: addressed shadow writes, atomic commit to the
// active outputs, one-cycle registered readback, write lock and error pulse.
module reg_bank_cfg
  import fc_cfg_pkg::*;
#(
  parameter int unsigned           NREG    = CFG_NREG,
  parameter int unsigned           DW      = CFG_DW,
  parameter int unsigned           AW      = CFG_AW,
  parameter logic [NREG*DW-1:0]    WMASK   = {NREG{{DW{1'b1}}}},
  parameter logic [NREG*DW-1:0]    RST_VAL = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [AW-1:0]        ADDR,
  input  logic [DW-1:0]        DIN,
  input  logic                 WR,
  input  logic                 RD,
  input  logic                 RSEL,
  input  logic                 COMMIT,
  input  logic                 LOCK,
  output logic [NREG*DW-1:0]   DREG,
  output logic [DW-1:0]        RDATA,
  output logic                 RVALID,
  output logic                 DIRTY,
  output logic                 WERR
);

  localparam logic [AW:0] NREG_LIM = (AW+1)'(NREG);

  logic [DW-1:0] shadow_v [NREG];
  logic [DW-1:0] active_v [NREG];
  logic          addr_ok_c;
  logic          wr_ok_c;
  logic [DW-1:0] rmux_c;

  // One extra bit so NREG == 2^AW compares correctly
  assign addr_ok_c = ({1'b0, ADDR} < NREG_LIM);
  assign wr_ok_c   = WR && !LOCK && addr_ok_c;

  for (genvar k = 0; k < NREG; k++) begin : g_reg
    logic we_c;
    assign we_c = wr_ok_c && (ADDR == AW'(k));

    shadow_reg #(
      .DW      (DW),
      .MASK    (WMASK[k*DW +: DW]),
      .RST_VAL (RST_VAL[k*DW +: DW])
    ) u_reg (
      .clk    (CLK),
      .rst    (RST),
      .we     (we_c),
      .commit (COMMIT),
      .wdata  (DIN),
      .shadow (shadow_v[k]),
      .active (active_v[k])
    );

    assign DREG[k*DW +: DW] = active_v[k];
  end

  always_comb begin
    rmux_c = '0;
    for (int unsigned k = 0; k < NREG; k++) begin
      if (ADDR == AW'(k)) begin
        rmux_c = RSEL ? shadow_v[k] : active_v[k];
      end
    end
  end

  // Readback, dirty tracking and error pulse; reads see pre-edge values
  always_ff @(posedge CLK) begin
    if (RST) begin
      RDATA  <= '0;
      RVALID <= 1'b0;
      DIRTY  <= 1'b0;
      WERR   <= 1'b0;
    end else begin
      RVALID <= RD;
      if (RD) begin
        RDATA <= addr_ok_c ? rmux_c : '0;
      end
      if (COMMIT) begin
        DIRTY <= 1'b0;
      end else if (wr_ok_c) begin
        DIRTY <= 1'b1;
      end
      WERR <= (WR && !wr_ok_c) || (RD && !addr_ok_c);
    end
  end

endmodule

// File: tb/tb_reg_bank_cfg.sv
// Self-checking bench for reg_bank_cfg: reference model of shadow/active
// registers plus a read scoreboard queue popped when RVALID appears.
module tb_reg_bank_cfg;
  import fc_cfg_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, WR, RD, RSEL, COMMIT, LOCK;
  logic [3:0]  ADDR;
  logic [7:0]  DIN;
  logic [23:0] DREG;
  logic [7:0]  RDATA;
  logic        RVALID, DIRTY, WERR;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] msk [3] = '{8'hFF, 8'h3F, 8'h0F};
  logic [7:0] sh [3];
  logic [7:0] ac [3];
  logic       dirty_m;
  logic       werr_m;
  logic       rvalid_m;
  logic [7:0] rq [$];
  logic [7:0] exp_rd;

  reg_bank_cfg #(
    .NREG(3), .DW(8), .AW(4), .WMASK(CFG_WMASK), .RST_VAL(CFG_RST_VAL)
  ) dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .DIN(DIN), .WR(WR), .RD(RD),
    .RSEL(RSEL), .COMMIT(COMMIT), .LOCK(LOCK), .DREG(DREG), .RDATA(RDATA),
    .RVALID(RVALID), .DIRTY(DIRTY), .WERR(WERR)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle, advance the model, push read expectations, sample at edge+1
  task automatic cycle(input logic rst, input logic wr, input logic [3:0] addr,
                       input logic [7:0] din, input logic rd, input logic rsel,
                       input logic commit, input logic lock);
    logic aok, wok;
    RST = rst; WR = wr; ADDR = addr; DIN = din; RD = rd;
    RSEL = rsel; COMMIT = commit; LOCK = lock;
    aok = (addr < 4'd3);
    wok = wr && !lock && aok;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        sh[k] = CFG_RST_VAL[k*8 +: 8] & msk[k];
        ac[k] = sh[k];
      end
      dirty_m = 1'b0; werr_m = 1'b0; rvalid_m = 1'b0;
      rq.delete();
    end else begin
      if (rd) rq.push_back(aok ? (rsel ? sh[addr[1:0]] : ac[addr[1:0]]) : 8'h00);
      rvalid_m = rd;
      werr_m = (wr && !wok) || (rd && !aok);
      if (wok) sh[addr[1:0]] = din & msk[addr[1:0]];
      if (commit) for (int k = 0; k < 3; k++) ac[k] = sh[k];
      if (commit) dirty_m = 1'b0;
      else if (wok) dirty_m = 1'b1;
    end
    @(posedge CLK);
    #1;
    RST = 1'b0; WR = 1'b0; RD = 1'b0; COMMIT = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 4'd0, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (DREG !== 24'h003FA5) begin
      miscompares++; $display("FAIL reset_dreg: got %h want %h", DREG, 24'h003FA5);
    end
    vectors++;
    if ({DIRTY, WERR, RVALID} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags: got %b want 000", {DIRTY, WERR, RVALID});
    end
    vectors++;
    if (RDATA !== 8'h00) begin
      miscompares++; $display("FAIL reset_rdata: got %h want 00", RDATA);
    end
  endtask

  task automatic test_write_commit();
    cycle(1'b0, 1'b1, 4'd2, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (DREG !== 24'h003FA5 || DIRTY !== 1'b1) begin
      miscompares++; $display("FAIL wr_shadow: got dreg=%h dirty=%b want 003fa5 1", DREG, DIRTY);
    end
    cycle(1'b0, 1'b0, 4'd2, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    vectors++;
    exp_rd = (rq.size() > 0) ? rq.pop_front() : 8'hXX;
    if (RVALID !== 1'b1 || RDATA !== 8'h0F || exp_rd !== 8'h0F) begin
      miscompares++; $display("FAIL rd_shadow: got v=%b d=%h want 1 0f", RVALID, RDATA);
    end
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (DREG[23:16] !== 8'h0F || DIRTY !== 1'b0) begin
      miscompares++; $display("FAIL commit: got %h dirty=%b want 0f 0", DREG[23:16], DIRTY);
    end
  endtask

  task automatic test_merge();
    cycle(1'b0, 1'b1, 4'd0, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (DREG !== 24'h0F3F12 || DIRTY !== 1'b0) begin
      miscompares++; $display("FAIL merge: got %h dirty=%b want 0f3f12 0", DREG, DIRTY);
    end
  endtask

  task automatic test_errors();
    cycle(1'b0, 1'b1, 4'd1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (WERR !== 1'b1 || DIRTY !== 1'b0) begin
      miscompares++; $display("FAIL lock_wr: got werr=%b dirty=%b want 1 0", WERR, DIRTY);
    end
    cycle(1'b0, 1'b0, 4'd1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    vectors++;
    exp_rd = (rq.size() > 0) ? rq.pop_front() : 8'hXX;
    if (WERR !== 1'b0 || RVALID !== 1'b1 || RDATA !== 8'h3F || exp_rd !== 8'h3F) begin
      miscompares++; $display("FAIL lock_keep: got werr=%b d=%h want 0 3f", WERR, RDATA);
    end
    cycle(1'b0, 1'b0, 4'd5, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    exp_rd = (rq.size() > 0) ? rq.pop_front() : 8'hXX;
    if (RDATA !== exp_rd || RVALID !== 1'b1 || WERR !== 1'b1) begin
      miscompares++; $display("FAIL rd_oor: got d=%h v=%b e=%b want %h 1 1", RDATA, RVALID, WERR, exp_rd);
    end
    // Out-of-range RD and WR together: one pulse, then quiet
    cycle(1'b0, 1'b1, 4'd7, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    void'(rq.pop_front());
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (WERR !== 1'b0 || DREG !== 24'h0F3F12) begin
      miscompares++; $display("FAIL werr_single: got e=%b dreg=%h want 0 0f3f12", WERR, DREG);
    end
    // Commit is still honoured while locked
    cycle(1'b0, 1'b1, 4'd1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (DREG !== 24'h0F2112 || DIRTY !== 1'b0) begin
      miscompares++; $display("FAIL commit_locked: got %h want 0f2112", DREG);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, 1'b1, 4'd0, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 4'd1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 4'd2, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int a = 0; a < 3; a++) begin
      cycle(1'b0, 1'b0, 4'(a), 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      vectors++;
      exp_rd = (rq.size() > 0) ? rq.pop_front() : 8'hXX;
      if (RVALID !== 1'b1 || RDATA !== exp_rd) begin
        miscompares++; $display("FAIL b2b_rd%0d: got v=%b d=%h want 1 %h", a, RVALID, RDATA, exp_rd);
      end
    end
    vectors++;
    if (DREG !== 24'h0F2112 || DIRTY !== 1'b1) begin
      miscompares++; $display("FAIL b2b_precommit: got %h want 0f2112", DREG);
    end
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (DREG !== 24'h0332A1 || RVALID !== 1'b0) begin
      miscompares++; $display("FAIL b2b_commit: got %h want 0332a1", DREG);
    end
    // Same-address RD and WR: pre-edge shadow value comes back
    cycle(1'b0, 1'b1, 4'd0, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    vectors++;
    exp_rd = (rq.size() > 0) ? rq.pop_front() : 8'hXX;
    if (RDATA !== 8'hA1 || exp_rd !== 8'hA1) begin
      miscompares++; $display("FAIL rd_wr_same: got %h want a1", RDATA);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b1, 4'd1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (DREG !== 24'h003FA5 || DIRTY !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid: got %h dirty=%b want 003fa5 0", DREG, DIRTY);
    end
    cycle(1'b0, 1'b0, 4'd1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    vectors++;
    exp_rd = (rq.size() > 0) ? rq.pop_front() : 8'hXX;
    if (RDATA !== 8'h3F || exp_rd !== 8'h3F) begin
      miscompares++; $display("FAIL rst_mid_shadow: got %h want 3f", RDATA);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), 1'($urandom), 4'($urandom_range(0, 5)),
            8'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0));
      vectors++;
      if (DREG !== {ac[2], ac[1], ac[0]} || DIRTY !== dirty_m || WERR !== werr_m ||
          RVALID !== rvalid_m) begin
        miscompares++;
        $display("FAIL rand%0d: got %h %b%b%b want %h %b%b%b", i, DREG, DIRTY, WERR, RVALID,
                 {ac[2], ac[1], ac[0]}, dirty_m, werr_m, rvalid_m);
      end
      if (rvalid_m) begin
        vectors++;
        exp_rd = (rq.size() > 0) ? rq.pop_front() : 8'hXX;
        if (RDATA !== exp_rd) begin
          miscompares++; $display("FAIL rand_rd%0d: got %h want %h", i, RDATA, exp_rd);
        end
      end
    end
  endtask

  initial begin
    RST = 1'b0; WR = 1'b0; RD = 1'b0; RSEL = 1'b0; COMMIT = 1'b0; LOCK = 1'b0;
    ADDR = '0; DIN = '0;
    dirty_m = 1'b0; werr_m = 1'b0; rvalid_m = 1'b0;
    test_reset();
    test_write_commit();
    test_merge();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
